// File: rtl/nv_nvdla_cvif_axi_pkg.sv
// nv_nvdla_cvif_axi_pkg: shared widths, FSM states and AW entry layout for the CVIF NoC write responder
package nv_nvdla_cvif_axi_pkg;
    localparam int ID_W       = 8;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 512;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int LEN_W      = 4;
    localparam int OS_W       = 4;
    typedef enum logic {IDLE, DATA} wr_state_e;
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } aw_entry_t;
endpackage

// File: rtl/nv_nvdla_cvif_wr_rsp_fifo.sv
// nv_nvdla_cvif_wr_rsp_fifo: synchronous flop FIFO; a push on a full queue is taken only alongside a pop
module nv_nvdla_cvif_wr_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [PW:0]      cnt_q;
    logic             do_pop, do_push;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rp_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= do_push ? wp_q + PW'(1) : wp_q;
            rp_q  <= do_pop ? rp_q + PW'(1) : rp_q;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/nv_nvdla_cvif_noc_wr_responder.sv
// nv_nvdla_cvif_noc_wr_responder: AXI AW/W/B target draining W beats to a backpressured memory port
// with in-order B responses, sticky protocol error flag and outstanding-burst count.
module nv_nvdla_cvif_noc_wr_responder
    import nv_nvdla_cvif_axi_pkg::*;
#(
    parameter int AW_DEPTH = 4,
    parameter int B_DEPTH  = 4
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  cvif2noc_axi_aw_awvalid,
    output logic                  cvif2noc_axi_aw_awready,
    input  logic [ID_W-1:0]       cvif2noc_axi_aw_awid,
    input  logic [LEN_W-1:0]      cvif2noc_axi_aw_awlen,
    input  logic [ADDR_W-1:0]     cvif2noc_axi_aw_awaddr,
    input  logic                  cvif2noc_axi_w_wvalid,
    output logic                  cvif2noc_axi_w_wready,
    input  logic [DATA_W-1:0]     cvif2noc_axi_w_wdata,
    input  logic [BEAT_BYTES-1:0] cvif2noc_axi_w_wstrb,
    input  logic                  cvif2noc_axi_w_wlast,
    output logic                  noc2cvif_axi_b_bvalid,
    input  logic                  noc2cvif_axi_b_bready,
    output logic [ID_W-1:0]       noc2cvif_axi_b_bid,
    output logic                  mem_wr_en,
    input  logic                  mem_wr_ready,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    output logic [BEAT_BYTES-1:0] mem_wr_strb,
    output logic                  wr_err,
    output logic [OS_W-1:0]       wr_os_cnt
);
    aw_entry_t         aw_in, aw_head;
    logic              aw_full, aw_empty, aw_pop, aw_hs;
    logic [ID_W-1:0]   b_head;
    logic              b_full, b_empty, b_push, b_hs;
    wr_state_e         state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic              err_q, err_d, rdy_q, w_hs, last;
    logic [OS_W-1:0]   os_q, os_d;
    assign aw_in = '{id: cvif2noc_axi_aw_awid, len: cvif2noc_axi_aw_awlen, addr: cvif2noc_axi_aw_awaddr};
    // rdy_q keeps awready low while reset is held and for the first cycle after it
    assign cvif2noc_axi_aw_awready = rdy_q & ~aw_full;
    assign aw_hs = cvif2noc_axi_aw_awvalid & cvif2noc_axi_aw_awready;
    assign cvif2noc_axi_w_wready = (state_q == DATA) & mem_wr_ready & ~b_full;
    assign w_hs  = cvif2noc_axi_w_wvalid & cvif2noc_axi_w_wready;
    assign last  = cnt_q == len_q;
    assign noc2cvif_axi_b_bvalid = ~b_empty;
    assign noc2cvif_axi_b_bid    = b_empty ? '0 : b_head;
    assign b_hs  = noc2cvif_axi_b_bvalid & noc2cvif_axi_b_bready;
    assign mem_wr_en   = w_hs;
    assign mem_wr_addr = w_hs ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wr_data = w_hs ? cvif2noc_axi_w_wdata : '0;
    assign mem_wr_strb = w_hs ? cvif2noc_axi_w_wstrb : '0;
    assign wr_err    = err_q;
    assign wr_os_cnt = os_q;
    assign os_d = os_q + OS_W'(aw_hs) - OS_W'(b_hs);
    nv_nvdla_cvif_wr_rsp_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_q (
        .clk_i(nvdla_core_clk), .rst_i(nvdla_core_rst),
        .push_i(aw_hs), .din_i(aw_in), .pop_i(aw_pop), .dout_o(aw_head),
        .full_o(aw_full), .empty_o(aw_empty)
    );
    nv_nvdla_cvif_wr_rsp_fifo #(.WIDTH(ID_W), .DEPTH(B_DEPTH)) u_b_q (
        .clk_i(nvdla_core_clk), .rst_i(nvdla_core_rst),
        .push_i(b_push), .din_i(id_q), .pop_i(b_hs), .dout_o(b_head),
        .full_o(b_full), .empty_o(b_empty)
    );
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        aw_pop  = 1'b0;
        b_push  = 1'b0;
        if (state_q == IDLE) begin
            if (!aw_empty) begin
                aw_pop  = 1'b1;
                id_d    = aw_head.id;
                addr_d  = aw_head.addr;
                len_d   = aw_head.len;
                cnt_d   = '0;
                err_d   = err_q | (aw_head.addr[OFF_W-1:0] != '0);
                state_d = DATA;
            end
        end else if (w_hs) begin
            // burst length comes from awlen; wlast only feeds the error flag
            addr_d = addr_q + ADDR_W'(BEAT_BYTES);
            cnt_d  = cnt_q + LEN_W'(1);
            err_d  = err_q | (cvif2noc_axi_w_wlast != last);
            b_push = last;
            state_d = last ? IDLE : DATA;
        end
    end
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            os_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            os_q    <= os_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nv_nvdla_cvif_noc_wr_responder.sv
// tb_nv_nvdla_cvif_noc_wr_responder: vector table plus hand sequences, scoreboarded memory writes and B ids
module tb_nv_nvdla_cvif_noc_wr_responder;
    import nv_nvdla_cvif_axi_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic awvalid = 1'b0, awready;
    logic [ID_W-1:0] awid = '0;
    logic [LEN_W-1:0] awlen = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic [BEAT_BYTES-1:0] wstrb = '0;
    logic bvalid, bready = 1'b1;
    logic [ID_W-1:0] bid;
    logic mem_en, mem_ready = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [BEAT_BYTES-1:0] mem_strb;
    logic err;
    logic [OS_W-1:0] os;
    int n_chk = 0, n_fail = 0;
    typedef struct {logic [ADDR_W-1:0] addr; logic [31:0] d;} mexp_t;
    typedef struct {logic [7:0] id; logic [3:0] len; logic [63:0] addr; int wl; logic err;} vec_t;
    mexp_t mq[$];
    logic [ID_W-1:0] bq[$];
    mexp_t me;
    logic [ID_W-1:0] be;
    vec_t v[6];

    nv_nvdla_cvif_noc_wr_responder dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .cvif2noc_axi_aw_awvalid(awvalid), .cvif2noc_axi_aw_awready(awready),
        .cvif2noc_axi_aw_awid(awid), .cvif2noc_axi_aw_awlen(awlen), .cvif2noc_axi_aw_awaddr(awaddr),
        .cvif2noc_axi_w_wvalid(wvalid), .cvif2noc_axi_w_wready(wready),
        .cvif2noc_axi_w_wdata(wdata), .cvif2noc_axi_w_wstrb(wstrb), .cvif2noc_axi_w_wlast(wlast),
        .noc2cvif_axi_b_bvalid(bvalid), .noc2cvif_axi_b_bready(bready), .noc2cvif_axi_b_bid(bid),
        .mem_wr_en(mem_en), .mem_wr_ready(mem_ready), .mem_wr_addr(mem_addr),
        .mem_wr_data(mem_data), .mem_wr_strb(mem_strb), .wr_err(err), .wr_os_cnt(os)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_en) begin
            if (mq.size() == 0) chk("mem_unexpected_write", mem_addr, 64'hDEAD);
            else begin
                me = mq.pop_front();
                chk("mem_addr", mem_addr, me.addr);
                chk("mem_data", {32'b0, mem_data[31:0]}, {32'b0, me.d});
                chk("mem_strb", {32'b0, mem_strb[31:0]}, 64'hFFFF_FFFF);
            end
        end
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", {56'b0, bid}, 64'hDEAD);
            else begin
                be = bq.pop_front();
                chk("bid", {56'b0, bid}, {56'b0, be});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        bq.delete();
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr);
        int t = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; awid = id; awlen = len; awaddr = addr;
        while (!awready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) chk("aw_timeout", 64'(t), 64'd0);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic l);
        int t = 0;
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = {16{d}}; wstrb = '1; wlast = l;
        while (!wready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) chk("w_timeout", 64'(t), 64'd0);
        @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((mq.size() != 0 || bq.size() != 0) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("drain_timeout", 64'(mq.size() + bq.size()), 64'd0);
        mq.delete();
        bq.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [3:0] len, input logic [63:0] addr, input int wl);
        logic [31:0] d;
        bq.push_back(id);
        send_aw(id, len, addr);
        for (int i = 0; i <= int'(len); i++) begin
            d = {id, 8'h00, 16'(i)};
            mq.push_back('{(addr + 64'(i) * 64) & ~64'h3F, d});
            send_w(d, i == wl);
        end
    endtask

    initial begin
        v[0] = '{8'h05, 4'd0, 64'h1000, 0, 1'b0};
        v[1] = '{8'h11, 4'd3, 64'h2000, 3, 1'b0};
        v[2] = '{8'h22, 4'd3, 64'h4000, 1, 1'b1};
        v[3] = '{8'h33, 4'd0, 64'h1010, 0, 1'b1};
        v[4] = '{8'h44, 4'd1, 64'hFFFF_FFFF_FFFF_FFC0, 1, 1'b0};
        v[5] = '{8'h55, 4'd2, 64'h8000, 15, 1'b1};
        do_reset();
        @(negedge clk);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_err", err, 0);
        chk("rst_os", os, 0);
        chk("rst_wready", wready, 0);
        for (int k = 0; k < 6; k++) begin
            do_reset();
            run_burst(v[k].id, v[k].len, v[k].addr, v[k].wl);
            wait_drain();
            chk($sformatf("vec%0d_err", k), err, v[k].err);
            chk($sformatf("vec%0d_os", k), os, 0);
        end
        // minimum latency: AW at N, W at N+2, B at N+3
        do_reset();
        @(posedge clk); #1;
        bq.push_back(8'h05);
        mq.push_back('{64'h1000, 32'hA5A5_0001});
        awvalid = 1'b1; awid = 8'h05; awlen = 4'd0; awaddr = 64'h1000;
        wvalid = 1'b1; wdata = {16{32'hA5A5_0001}}; wstrb = '1; wlast = 1'b1;
        @(negedge clk);
        chk("lat_awready_n", awready, 1);
        chk("lat_wready_n", wready, 0);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        chk("lat_wready_n1", wready, 0);
        chk("lat_bvalid_n1", bvalid, 0);
        @(negedge clk);
        chk("lat_wready_n2", wready, 1);
        chk("lat_mem_en_n2", mem_en, 1);
        chk("lat_bvalid_n2", bvalid, 0);
        @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("lat_bvalid_n3", bvalid, 1);
        chk("lat_bid_n3", {56'b0, bid}, 64'h05);
        wait_drain();
        // B queue full stalls W; bids drain in order once bready rises
        do_reset();
        bready = 1'b0;
        for (int i = 1; i <= 4; i++) run_burst(8'(i), 4'd0, 64'(i) * 64'h100, 0);
        bq.push_back(8'h05);
        mq.push_back('{64'h500, 32'h0505_0000});
        send_aw(8'h05, 4'd0, 64'h500);
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = {16{32'h0505_0000}}; wstrb = '1; wlast = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bfull_wready", wready, 0);
        end
        chk("bfull_os", os, 5);
        chk("bfull_bvalid", bvalid, 1);
        @(posedge clk); #1 bready = 1'b1;
        begin
            int t = 0;
            while (!wready && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) chk("bfull_w_timeout", 64'(t), 64'd0);
            @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
        end
        wait_drain();
        chk("bfull_os_end", os, 0);
        chk("bfull_err", err, 0);
        // AW acceptance with no W traffic: 4 queued + 1 in DATA
        do_reset();
        @(posedge clk); #1;
        awvalid = 1'b1; awlen = 4'd0; awaddr = 64'h0;
        for (int k = 0; k < 6; k++) begin
            awid = 8'(k);
            @(negedge clk);
            chk($sformatf("awfill_awready%0d", k), awready, k < 5);
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        @(negedge clk);
        chk("awfill_os", os, 5);
        // reset during beat 2 of 4, then a fresh burst
        do_reset();
        send_aw(8'h66, 4'd3, 64'h3000);
        mq.push_back('{64'h3000, 32'h6600_0000});
        send_w(32'h6600_0000, 1'b0);
        mq.push_back('{64'h3040, 32'h6600_0001});
        send_w(32'h6600_0001, 1'b0);
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = {16{32'h6600_0002}}; wstrb = '1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mq_done", 64'(mq.size()), 0);
        chk("midrst_awready", awready, 0);
        chk("midrst_wready", wready, 0);
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_err", err, 0);
        chk("midrst_os", os, 0);
        do_reset();
        run_burst(8'h77, 4'd1, 64'h5000, 1);
        wait_drain();
        chk("postrst_err", err, 0);
        chk("postrst_os", os, 0);
        chk("postrst_bvalid", bvalid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
